// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// pipeline WB stage (priority) and a FIFO of long-latency aux results.
// Params: DEPTH (aux FIFO entries, pow2), MAX_WAIT (starvation limit).
// Ports:
//   clk, rst                  clock, sync active-high reset
//   pipe_wen/wa/wd            pipeline writeback request
//   pipe_stall                one-cycle WB freeze while aux drains
//   aux_valid/wa/wd, aux_ready  aux write source (valid/ready)
//   chk_ra1/ra2/wa, hazard    decode check against pending aux writes
//   Wen/Wa/Wd                 register file write port
// Optional: `define RF_ARB_STATS_EN adds stat_force/stat_defer counters.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  output logic        pipe_stall,
  input  logic        aux_valid,
  input  logic [4:0]  aux_wa,
  input  logic [31:0] aux_wd,
  output logic        aux_ready,
  input  logic [4:0]  chk_ra1,
  input  logic [4:0]  chk_ra2,
  input  logic [4:0]  chk_wa,
  output logic        hazard,
`ifdef RF_ARB_STATS_EN
  output logic [15:0] stat_force,
  output logic [15:0] stat_defer,
`endif
  output logic        Wen,
  output logic [4:0]  Wa,
  output logic [31:0] Wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [7:0]    wait_q;
  logic [4:0]    mem_wa [DEPTH];
  logic [31:0]   mem_wd [DEPTH];

  logic full;
  logic empty;
  logic pipe_req;
  logic in_force;
  logic pop;
  logic push;
  logic hz;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pipe_req = pipe_wen && (pipe_wa != '0);
  assign in_force = (state_q == FORCE);

  // During FORCE the head wins even over a live pipe write.
  assign pop  = !rst && !empty && (in_force || !pipe_req);
  // Full refuses a push even if a pop frees a slot this cycle.
  // x0 writes are acknowledged but dropped.
  assign push = !rst && aux_valid && !full && (aux_wa != '0);

  assign aux_ready  = !rst && !full;
  assign pipe_stall = !rst && in_force;
  assign hazard     = !rst && hz;

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    Wen = 1'b0;
    Wa  = '0;
    Wd  = '0;
    if (pop) begin
      Wen = 1'b1;
      Wa  = mem_wa[rd_ptr];
      Wd  = mem_wd[rd_ptr];
    end else if (!rst && pipe_req) begin
      Wen = 1'b1;
      Wa  = pipe_wa;
      Wd  = pipe_wd;
    end
  end

  // Head entry still counts while popping (conservative).
  always_comb begin
    logic [AW-1:0] idx;
    logic [4:0]    ewa;
    hz  = 1'b0;
    idx = '0;
    ewa = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      ewa = mem_wa[idx];
      if (CW'(i) < count) begin
        if ((chk_ra1 != '0 && ewa == chk_ra1) ||
            (chk_ra2 != '0 && ewa == chk_ra2) ||
            (chk_wa  != '0 && ewa == chk_wa))
          hz = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wait_q  <= '0;
      state_q <= IDLE;
    end else begin
      if (push) begin
        mem_wa[wr_ptr] <= aux_wa;
        mem_wd[wr_ptr] <= aux_wd;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;

      unique case (state_q)
        IDLE: begin
          wait_q  <= '0;
          state_q <= (count_n != '0) ? PEND : IDLE;
        end
        PEND: begin
          if (count_n == '0) begin
            wait_q  <= '0;
            state_q <= IDLE;
          end else if (pop) begin
            wait_q  <= '0;
          end else if (wait_q == 8'(MAX_WAIT)) begin
            state_q <= FORCE;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        FORCE: begin
          wait_q  <= '0;
          state_q <= (count_n != '0) ? PEND : IDLE;
        end
        default: begin
          wait_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_force <= '0;
      stat_defer <= '0;
    end else begin
      if (in_force && stat_force != 16'hFFFF)
        stat_force <= stat_force + 16'd1;
      if (!empty && pipe_req && !in_force &&
          stat_defer != 16'hFFFF)
        stat_defer <= stat_defer + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed + random stimulus checked
// against a queue-based model of the write-port arbiter.
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        aux_valid;
  logic [4:0]  aux_wa;
  logic [31:0] aux_wd;
  logic        aux_ready;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic [4:0]  chk_wa;
  logic        hazard;
  logic        Wen;
  logic [4:0]  Wa;
  logic [31:0] Wd;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_force;
  logic [15:0] stat_defer;
`endif

  regfile_wb_arbiter #(
    .DEPTH(DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pipe_wen(pipe_wen),
    .pipe_wa(pipe_wa),
    .pipe_wd(pipe_wd),
    .pipe_stall(pipe_stall),
    .aux_valid(aux_valid),
    .aux_wa(aux_wa),
    .aux_wd(aux_wd),
    .aux_ready(aux_ready),
    .chk_ra1(chk_ra1),
    .chk_ra2(chk_ra2),
    .chk_wa(chk_wa),
    .hazard(hazard),
`ifdef RF_ARB_STATS_EN
    .stat_force(stat_force),
    .stat_defer(stat_defer),
`endif
    .Wen(Wen),
    .Wa(Wa),
    .Wd(Wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  int   starve;
  bit   force_m;

  int n_chk  = 0;
  int n_fail = 0;

  logic        o_wen;
  logic [4:0]  o_wa;
  logic [31:0] o_wd;
  logic        o_rdy;
  logic        o_stall;
  logic        o_hz;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit hits(input logic [4:0] wa);
    return (chk_ra1 != 0 && wa == chk_ra1) ||
           (chk_ra2 != 0 && wa == chk_ra2) ||
           (chk_wa  != 0 && wa == chk_wa);
  endfunction

  // One clock: check outputs mid-cycle vs model, then advance model.
  task automatic cycle();
    bit          pr;
    bit          ne;
    bit          popd;
    bit          e_wen;
    bit          e_rdy;
    bit          e_hz;
    bit          e_stall;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    @(negedge clk);
    pr = 0; ne = 0; popd = 0;
    e_wen = 0; e_rdy = 0; e_hz = 0; e_stall = 0;
    e_wa = 0; e_wd = 0;
    if (!rst) begin
      pr      = pipe_wen && pipe_wa != 0;
      ne      = q.size() != 0;
      e_rdy   = q.size() < DEPTH;
      e_stall = force_m;
      foreach (q[i]) if (hits(q[i].wa)) e_hz = 1;
      popd = ne && (force_m || !pr);
      if (popd) begin
        e_wen = 1; e_wa = q[0].wa; e_wd = q[0].wd;
      end else if (pr) begin
        e_wen = 1; e_wa = pipe_wa; e_wd = pipe_wd;
      end
    end
    o_wen = Wen; o_wa = Wa; o_wd = Wd;
    o_rdy = aux_ready; o_stall = pipe_stall; o_hz = hazard;
    check("wen", {31'd0, Wen}, {31'd0, e_wen});
    check("wa", {27'd0, Wa}, {27'd0, e_wa});
    check("wd", Wd, e_wd);
    check("ready", {31'd0, aux_ready}, {31'd0, e_rdy});
    check("stall", {31'd0, pipe_stall}, {31'd0, e_stall});
    check("hazard", {31'd0, hazard}, {31'd0, e_hz});
    if (rst) begin
      q.delete();
      starve  = 0;
      force_m = 0;
    end else begin
      if (popd) void'(q.pop_front());
      if (aux_valid && e_rdy && aux_wa != 0)
        q.push_back('{wa: aux_wa, wd: aux_wd});
      if (force_m) begin
        force_m = 0; starve = 0;
      end else if (popd || !ne) starve = 0;
      else if (starve == MAX_WAIT) force_m = 1;
      else starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pipe_wen = 0; pipe_wa = 0; pipe_wd = 0;
    aux_valid = 0; aux_wa = 0; aux_wd = 0;
    chk_ra1 = 0; chk_ra2 = 0; chk_wa = 0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int   nst;
    int   at;
    logic [4:0] got[$];

    rst = 1; quiet();
    starve = 0; force_m = 0;
    cycle(); cycle();
    rst = 0;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_wen", {31'd0, o_wen}, 0);
      check("idle_rdy", {31'd0, o_rdy}, 1);
      check("idle_hz", {31'd0, o_hz}, 0);
      check("idle_stall", {31'd0, o_stall}, 0);
    end

    // aux only
    chk_ra1 = 5;
    aux_valid = 1; aux_wa = 5; aux_wd = 32'hDEADBEEF;
    cycle();
    check("aux_hz_n", {31'd0, o_hz}, 0);
    aux_valid = 0;
    cycle();
    check("aux_wen", {31'd0, o_wen}, 1);
    check("aux_wa", {27'd0, o_wa}, 5);
    check("aux_wd", o_wd, 32'hDEADBEEF);
    check("aux_hz_n1", {31'd0, o_hz}, 1);
    cycle();
    check("aux_hz_n2", {31'd0, o_hz}, 0);
    idle(2);

    // collision
    pipe_wen = 1; pipe_wa = 3; pipe_wd = 1;
    aux_valid = 1; aux_wa = 4; aux_wd = 2;
    cycle();
    check("col_pipe_wa", {27'd0, o_wa}, 3);
    check("col_pipe_wd", o_wd, 1);
    quiet();
    cycle();
    check("col_aux_wa", {27'd0, o_wa}, 4);
    check("col_aux_wd", o_wd, 2);
    idle(2);

    // starvation
    aux_valid = 1; aux_wa = 9; aux_wd = 32'h5A5A;
    cycle();
    aux_valid = 0;
    pipe_wen = 1; pipe_wa = 7; pipe_wd = 32'h77;
    nst = 0; at = -1;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (at >= 0 && k == at + 1)
        check("st_after", {27'd0, o_wa}, 7);
      if (o_stall) begin
        nst++; at = k;
        check("st_wa", {27'd0, o_wa}, 9);
      end
    end
    check("st_cnt", nst, 1);
    check("st_at", at, 9);
    idle(2);

    // full FIFO under continuous pipe writes
    pipe_wen = 1; pipe_wa = 2; pipe_wd = 32'h22;
    for (int c = 0; c < 4; c++) begin
      aux_valid = 1; aux_wa = 5'(10 + c); aux_wd = c;
      cycle();
      check("fill_rdy", {31'd0, o_rdy}, 1);
    end
    aux_wa = 14; aux_wd = 4;
    cycle();
    check("full_rdy", {31'd0, o_rdy}, 0);
    pipe_wen = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (o_wen) got.push_back(o_wa);
      if (o_rdy && aux_valid) aux_valid = 0;
    end
    check("full_n", got.size(), 5);
    foreach (got[i]) check("full_ord", {27'd0, got[i]}, 10 + i);
    idle(2);

    // x0 push
    aux_valid = 1; aux_wa = 0; aux_wd = 32'h99;
    cycle();
    aux_valid = 0;
    cycle();
    check("x0_wen", {31'd0, o_wen}, 0);
    check("x0_rdy", {31'd0, o_rdy}, 1);

    // reset mid-operation with 3 queued
    pipe_wen = 1; pipe_wa = 1; pipe_wd = 32'h11;
    for (int c = 0; c < 3; c++) begin
      aux_valid = 1; aux_wa = 5'(20 + c); aux_wd = 32'(c);
      cycle();
    end
    aux_valid = 0; chk_ra1 = 20; chk_ra2 = 21; chk_wa = 22;
    rst = 1;
    cycle();
    check("rst_wen", {31'd0, o_wen}, 0);
    check("rst_hz", {31'd0, o_hz}, 0);
    rst = 0; pipe_wen = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("post_wen", {31'd0, o_wen}, 0);
      check("post_hz", {31'd0, o_hz}, 0);
    end

    // random
    begin
      int p = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 100 == 0) p = (n % 300 == 0) ? 95 : ((n % 200 == 0) ? 20 : 60);
        rst       = ($urandom_range(0, 299) == 0);
        pipe_wen  = ($urandom_range(0, 99) < p);
        pipe_wa   = 5'($urandom_range(0, 31));
        pipe_wd   = $urandom;
        aux_valid = ($urandom_range(0, 99) < 40);
        aux_wa    = 5'($urandom_range(0, 7));
        aux_wd    = $urandom;
        chk_ra1   = 5'($urandom_range(0, 7));
        chk_ra2   = 5'($urandom_range(0, 7));
        chk_wa    = 5'($urandom_range(0, 7));
        cycle();
      end
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
